multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port opcode, input, 4, instruction bits [15:12], sampled from the instruction register.
REQ-004 SHALL have port funct, input, 3, instruction bits [2:0], R-type operation select.
REQ-005 SHALL have port zero, input, 1, ALU zero flag, result==0.
REQ-006 SHALL have port alu_control, output, 3, ALU op: 000 add, 001 sub, 010 and, 011 or, 100 set-less-than.
REQ-007 SHALL have 1-bit outputs pc_en, i_or_d, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal.
REQ-008 SHALL have 2-bit outputs alu_src_b (00 reg B, 01 const 2, 10 sign-ext imm, 11 imm<<1) and pc_src (00 ALU result, 01 ALU-out reg, 10 jump target).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, IMM_EX, IMM_WB, JUMP_EX.
REQ-010 SHALL decode opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 J, 0110 SLTI.
REQ-011 SHALL in FETCH: ir_write=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_control=000, pc_src=00, pc_en=1; next DECODE.
REQ-012 SHALL in DECODE: alu_src_a=0, alu_src_b=11, alu_control=000; next per opcode: LW/SW->MEMADR, R->RTYPE_EX, BEQ->BEQ_EX, ADDI/SLTI->IMM_EX, J->JUMP_EX.
REQ-013 SHALL on undefined opcode in DECODE: pulse illegal=1 for that cycle, return to FETCH, no reg_write/mem_write.
REQ-014 SHALL in MEMADR: alu_src_a=1, alu_src_b=10, alu_control=000; next MEMRD if LW, MEMWR if SW.
REQ-015 SHALL in MEMRD: i_or_d=1 -> MEMWB; MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH; MEMWR: i_or_d=1, mem_write=1 -> FETCH.
REQ-016 SHALL in RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_control=funct; funct 101-111 map to 000.
REQ-017 SHALL in RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-018 SHALL in BEQ_EX: alu_src_a=1, alu_src_b=00, alu_control=001, pc_src=01, pc_en=zero (same cycle, combinational) -> FETCH.
REQ-019 SHALL in IMM_EX: alu_src_a=1, alu_src_b=10, alu_control=000 (ADDI) or 100 (SLTI); IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-020 SHALL in JUMP_EX: pc_src=10, pc_en=1 -> FETCH.
REQ-021 SHALL deassert every output not listed for a state; alu_control defaults 000.
REQ-022 SHALL give cycle counts: LW 5, SW 4, R 4, ADDI/SLTI 4, BEQ 3, J 3, illegal 2.
REQ-023 SHALL sample opcode/funct only in DECODE and execute states; they are stable while ir_write=0.

Reset
REQ-024 SHALL load FETCH on any clk edge with reset=1, including mid-instruction.
REQ-025 SHALL force all strobes (pc_en, ir_write, mem_write, reg_write, illegal) to 0 while reset=1; other outputs 0.
REQ-026 SHALL resume with FETCH outputs on the first cycle after reset falls.

Structure
REQ-027 SHALL place state encoding, opcode constants, alu_control codes and alu_src_b/pc_src codes in shared package mips16_pkg.
REQ-028 SHALL use sub-module alu_ctrl_dec (ALU-op class + funct -> alu_control), purely combinational.
REQ-029 SHALL keep one state register; all outputs decoded from state, plus zero for pc_en.

Verification
REQ-030 SHALL test LW (0001): FETCH,DECODE,MEMADR,MEMRD,MEMWB; MEMWB reg_write=1, mem_to_reg=1; 5 cycles.
REQ-031 SHALL test R-type funct=100: RTYPE_EX alu_control=100; RTYPE_WB reg_write=1, reg_dst=1.
REQ-032 SHALL test BEQ with zero=1 -> pc_en=1, pc_src=01 in BEQ_EX; zero=0 -> pc_en=0; both return to FETCH.
REQ-033 SHALL test opcode 1111 -> illegal=1 one cycle in DECODE, then FETCH, no writes.
REQ-034 SHALL test reset asserted in MEMWR -> next cycle FETCH, mem_write=0 throughout reset.
REQ-035 SHALL test funct=110 in RTYPE_EX -> alu_control=000.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared constants for the mips16 multicycle controller: state encoding,
// opcodes, ALU/operand/PC-source codes and the internal control bundle.
package mips16_pkg;

    // Controller state encoding
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RTYPE_EX = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BEQ_EX   = 4'd8;
    localparam logic [3:0] S_IMM_EX   = 4'd9;
    localparam logic [3:0] S_IMM_WB   = 4'd10;
    localparam logic [3:0] S_JUMP_EX  = 4'd11;

    // Opcodes, instruction bits [15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_SLTI  = 4'b0110;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // ALU-op class handed from the FSM to the ALU control decoder
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_SLT   = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Control bundle decoded from the state; all-zero is the idle/reset value
    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       illegal;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Opcodes 0111..1111 are undefined
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_SLTI;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: ALU-op class plus funct -> alu_control.
module alu_ctrl_dec
    import mips16_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct,
    output logic [2:0] alu_control
);

    // Map op class to ALU code; unused R-type funct values fall back to add
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            AOP_ADD:   alu_control = ALU_ADD;
            AOP_SUB:   alu_control = ALU_SUB;
            AOP_SLT:   alu_control = ALU_SLT;
            AOP_FUNCT: alu_control = (funct > ALU_SLT) ? ALU_ADD : funct;
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle mips16 control unit: Moore FSM with a single state register;
// outputs decoded from state only, except pc_en in BEQ_EX which follows zero.
module multicycle_ctrl
    import mips16_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src
);

    logic [3:0] state;
    logic [3:0] state_next;
    ctrl_t      ctrl;
    ctrl_t      ctrl_q;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state selection
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_next = S_MEMADR;
                    OP_RTYPE:         state_next = S_RTYPE_EX;
                    OP_BEQ:           state_next = S_BEQ_EX;
                    OP_ADDI, OP_SLTI: state_next = S_IMM_EX;
                    OP_J:             state_next = S_JUMP_EX;
                    default:          state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_next = S_MEMWB;
            S_RTYPE_EX: state_next = S_RTYPE_WB;
            S_IMM_EX:   state_next = S_IMM_WB;
            default:    state_next = S_FETCH;
        endcase
    end

    // Per-state control decode; everything not set stays deasserted
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_en     = 1'b1;
                ctrl.alu_src_b = SRCB_TWO;
                ctrl.pc_src    = PC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.illegal   = ~is_legal_op(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl.i_or_d = 1'b1;
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = AOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = AOP_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.pc_en     = zero;
            end
            S_IMM_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opcode == OP_SLTI) ? AOP_SLT : AOP_ADD;
            end
            S_IMM_WB:  ctrl.reg_write = 1'b1;
            S_JUMP_EX: begin
                ctrl.pc_src = PC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset masks the whole bundle; alu_op of zero also yields alu_control 000
    always_comb begin
        ctrl_q = reset ? '0 : ctrl;
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op      (ctrl_q.alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    assign pc_en      = ctrl_q.pc_en;
    assign i_or_d     = ctrl_q.i_or_d;
    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign illegal    = ctrl_q.illegal;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign pc_src     = ctrl_q.pc_src;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions, resets
// mid-instruction and a randomized instruction stream against a step model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       zero;
    logic [2:0] alu_control;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;

    int checks = 0;
    int errors = 0;

    typedef enum int {
        R_FETCH, R_DECODE, R_MEMADR, R_MEMRD, R_MEMWB, R_MEMWR,
        R_RTYPE_EX, R_RTYPE_WB, R_BEQ_EX, R_IMM_EX, R_IMM_WB, R_JUMP_EX
    } role_t;

    role_t seq[$];

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .alu_control (alu_control),
        .pc_en       (pc_en),
        .i_or_d      (i_or_d),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .illegal     (illegal),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {strobes/selects, alu_src_b, pc_src, alu_control}
    function automatic logic [15:0] observed();
        return {pc_en, i_or_d, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, illegal, alu_src_b, pc_src, alu_control};
    endfunction

    // Expected outputs for one step of an instruction, straight from the step table
    function automatic logic [15:0] role_out(role_t r, logic [3:0] op, logic [2:0] fn, logic z);
        logic pe = 0, iod = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, ill = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b000;
        case (r)
            R_FETCH:    begin irw = 1; pe = 1; sb = 2'b01; end
            R_DECODE:   begin sb = 2'b11; ill = (op > 4'd6); end
            R_MEMADR:   begin sa = 1; sb = 2'b10; end
            R_MEMRD:    iod = 1;
            R_MEMWB:    begin rw = 1; m2r = 1; end
            R_MEMWR:    begin iod = 1; mw = 1; end
            R_RTYPE_EX: begin sa = 1; ac = (fn <= 3'd4) ? fn : 3'd0; end
            R_RTYPE_WB: begin rw = 1; rd = 1; end
            R_BEQ_EX:   begin sa = 1; ac = 3'b001; ps = 2'b01; pe = z; end
            R_IMM_EX:   begin sa = 1; sb = 2'b10; ac = (op == 4'd6) ? 3'b100 : 3'b000; end
            R_IMM_WB:   rw = 1;
            R_JUMP_EX:  begin ps = 2'b10; pe = 1; end
            default:    ;
        endcase
        return {pe, iod, mw, irw, rw, rd, m2r, sa, ill, sb, ps, ac};
    endfunction

    // Sequence of steps an instruction walks through, from FETCH on
    task automatic build_plan(input logic [3:0] op);
        seq = {R_FETCH, R_DECODE};
        case (op)
            4'd0: seq = {seq, R_RTYPE_EX, R_RTYPE_WB};
            4'd1: seq = {seq, R_MEMADR, R_MEMRD, R_MEMWB};
            4'd2: seq = {seq, R_MEMADR, R_MEMWR};
            4'd3: seq = {seq, R_BEQ_EX};
            4'd4, 4'd6: seq = {seq, R_IMM_EX, R_IMM_WB};
            4'd5: seq = {seq, R_JUMP_EX};
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges checking all-zero outputs, then release into FETCH
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1 check({tag, "_hold0"}, observed(), 16'h0000);
        @(posedge clk); #1;
        check({tag, "_hold1"}, observed(), 16'h0000);
        @(posedge clk); #1;
        check({tag, "_hold2"}, observed(), 16'h0000);
        reset = 1'b0;
        #1 check({tag, "_resume"}, observed(), role_out(R_FETCH, opcode, funct, zero));
    endtask

    // Run one instruction from FETCH; zmode 0/1 holds zero, 2 randomizes it per cycle.
    // stop_at >= 0 asserts reset right after checking that step.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [2:0] fn,
                             input int zmode, input int stop_at);
        opcode = op;
        funct  = fn;
        build_plan(op);
        for (int k = 0; k < seq.size(); k++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1 check($sformatf("%s_step%0d", tag, k), observed(),
                     role_out(seq[k], op, fn, zero));
            if (k == stop_at) begin
                opcode = 4'($urandom_range(0, 15));
                do_reset({tag, "_rst"});
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 4'd0;
        funct  = 3'd0;
        zero   = 1'b0;
        @(posedge clk); #1;
        do_reset("init");

        run_instr("lw",       4'd1, 3'd0, 0, -1);
        run_instr("rtype100", 4'd0, 3'd4, 0, -1);
        run_instr("rtype110", 4'd0, 3'd6, 1, -1);
        run_instr("rtype111", 4'd0, 3'd7, 0, -1);
        run_instr("rtype011", 4'd0, 3'd3, 0, -1);
        run_instr("beq_z1",   4'd3, 3'd0, 1, -1);
        run_instr("beq_z0",   4'd3, 3'd0, 0, -1);
        run_instr("illegal",  4'd15, 3'd0, 1, -1);
        run_instr("sw",       4'd2, 3'd0, 0, -1);
        run_instr("addi",     4'd4, 3'd5, 1, -1);
        run_instr("slti",     4'd6, 3'd1, 0, -1);
        run_instr("jump",     4'd5, 3'd0, 0, -1);
        run_instr("ill7",     4'd7, 3'd2, 0, -1);
        run_instr("sw_rst",   4'd2, 3'd0, 0, 3);
        run_instr("lw_rst",   4'd1, 3'd0, 0, 2);
        run_instr("after_rst", 4'd0, 3'd2, 0, -1);

        for (int n = 0; n < 300; n++) begin
            int stop;
            stop = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            run_instr($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), 2, stop);
        end

        #1 check("final_fetch", observed(), role_out(R_FETCH, opcode, funct, zero));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
